// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes, FSM states and byte-enable constants shared by the memory-access stage.
package mem_stage_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_load_align import mem_stage_pkg::*; (
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data = opcode == OP_LB  ? {{24{b[7]}}, b} :
           opcode == OP_LBU ? {24'b0, b} :
           opcode == OP_LH  ? {{16{h[15]}}, h} :
           opcode == OP_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage with req/ack data memory and MEM/WB registers.
// MEM_SUBWORD_EN enables byte/halfword accesses; without it every access is a full word.
module mem_access_stage import mem_stage_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [5:0]        opcode,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [4:0]        write_reg,
  input  logic              signal_regWrite,
  input  logic              signal_memRead,
  input  logic              signal_memWrite,
  input  logic              signal_memToReg,
  input  logic              flush,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [31:0]       wb_write_data,
  output logic [4:0]        wb_write_reg,
  output logic              misalign
);
  state_t      state, state_nx;
  logic        is_mem, accept, mis;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx, load_data, l_alu;
  logic [4:0]  l_reg;
  logic        l_rw, l_m2r, l_rd;
  assign accept    = state == IDLE && in_valid && !flush;
  assign is_mem    = signal_memRead | signal_memWrite;
  assign stall_out = state == ACCESS;
`ifdef MEM_SUBWORD_EN
  logic [5:0] l_op;
  logic       half, byte_op;
  always_comb begin
    half     = opcode == OP_LH || opcode == OP_LHU || opcode == OP_SH;
    byte_op  = opcode == OP_LB || opcode == OP_LBU || opcode == OP_SB;
    mis      = is_mem && (byte_op ? 1'b0 : half ? alu_result[0] : |alu_result[1:0]);
    be_nx    = opcode == OP_SB ? 4'(BE_BYTE << alu_result[1:0]) :
               opcode == OP_SH ? (alu_result[1] ? BE_HI : BE_LO) : BE_ALL;
    wdata_nx = opcode == OP_SB ? {4{store_data[7:0]}} :
               opcode == OP_SH ? {2{store_data[15:0]}} : store_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) l_op <= '0;
    else if (accept) l_op <= opcode;
  mem_load_align u_align (
    .opcode  (l_op),
    .addr_lo (l_alu[1:0]),
    .rdata   (dmem_rdata),
    .data    (load_data)
  );
`else
  logic unused_opcode;
  assign unused_opcode = ^opcode;
  assign mis       = is_mem && |alu_result[1:0];
  assign be_nx     = BE_ALL;
  assign wdata_nx  = store_data;
  assign load_data = dmem_rdata;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept && is_mem && !mis ? ACCESS : IDLE;
    else state_nx = dmem_ack ? IDLE : ACCESS;
  end
  // dmem_* stay untouched while in ACCESS, so the request is stable until ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      wb_valid      <= 1'b0;
      wb_regWrite   <= 1'b0;
      wb_write_data <= '0;
      wb_write_reg  <= '0;
      misalign      <= 1'b0;
      l_alu         <= '0;
      l_reg         <= '0;
      l_rw          <= 1'b0;
      l_m2r         <= 1'b0;
      l_rd          <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      misalign    <= 1'b0;
      if (accept) begin
        wb_write_data <= alu_result;
        wb_write_reg  <= write_reg;
        wb_valid      <= !is_mem || mis;
        wb_regWrite   <= !is_mem && signal_regWrite;
        misalign      <= mis;
        if (is_mem && !mis) begin
          dmem_req   <= 1'b1;
          dmem_we    <= signal_memWrite;
          dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
          dmem_wdata <= wdata_nx;
          dmem_be    <= be_nx;
          l_alu      <= alu_result;
          l_reg      <= write_reg;
          l_rw       <= signal_regWrite;
          l_m2r      <= signal_memToReg;
          l_rd       <= signal_memRead;
        end
      end else if (stall_out && dmem_ack) begin
        dmem_req      <= 1'b0;
        wb_valid      <= 1'b1;
        wb_regWrite   <= l_rw && !dmem_we;
        wb_write_data <= l_rd && l_m2r ? load_data : l_alu;
        wb_write_reg  <= l_reg;
      end
    end
endmodule
